// File: rtl/vdp_pkg.sv
// vdp_pkg: shared tile map geometry defaults and the tile map entry type
package vdp_pkg;
  localparam int MAP_W_LOG2_DEF = 5;
  localparam int MAP_H_LOG2_DEF = 5;
  localparam int DATA_W_DEF = 16;
  typedef logic [DATA_W_DEF-1:0] tile_entry_t;
endpackage

// File: rtl/tile_map_ram.sv
// tile_map_ram: simple dual-port read-first RAM, registered read port with enable, byte-enable write port
module tile_map_ram #(
  parameter int AW = 10,
  parameter int DATA_W = 16,
  parameter string FILENAME = ""
) (
  input  logic                clk,
  input  logic [DATA_W/8-1:0] wr_be_i,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic                rd_en_i,
  input  logic [AW-1:0]       rd_addr_i,
  output logic [DATA_W-1:0]   rd_data_o
);
  logic [DATA_W-1:0] mem_q [2**AW];
  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W/8; i++)
      if (wr_be_i[i]) mem_q[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end
endmodule

// File: rtl/tile_map_scroll.sv
// tile_map_scroll: scrolled tile map lookup with 2-cycle read pipeline and read-priority write port
module tile_map_scroll
  import vdp_pkg::*;
#(
  parameter int MAP_W_LOG2 = MAP_W_LOG2_DEF,
  parameter int MAP_H_LOG2 = MAP_H_LOG2_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter string FILENAME = ""
) (
  input  logic                  clk_draw,
  input  logic                  rst_draw_n,
  input  logic                  frame_start,
  input  logic [MAP_W_LOG2-1:0] scroll_x,
  input  logic [MAP_H_LOG2-1:0] scroll_y,
  input  logic                  rd_valid,
  input  logic [MAP_W_LOG2-1:0] rd_tile_x,
  input  logic [MAP_H_LOG2-1:0] rd_tile_y,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_data_valid,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [MAP_W_LOG2-1:0] wr_x,
  input  logic [MAP_H_LOG2-1:0] wr_y,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be
);
  localparam int AW = MAP_W_LOG2 + MAP_H_LOG2;
  logic [MAP_W_LOG2-1:0] scroll_x_q, scroll_x_d, ax_d;
  logic [MAP_H_LOG2-1:0] scroll_y_q, scroll_y_d, ay_d;
  logic [AW-1:0] addr_q, addr_d;
  logic v1_q, v2_q, have_q;
  logic [DATA_W-1:0] ram_q;
  always_comb begin
    scroll_x_d = frame_start ? scroll_x : scroll_x_q;
    scroll_y_d = frame_start ? scroll_y : scroll_y_q;
    ax_d = rd_tile_x + scroll_x_q;
    ay_d = rd_tile_y + scroll_y_q;
    addr_d = rd_valid ? {ay_d, ax_d} : addr_q;
  end
  always_ff @(posedge clk_draw or negedge rst_draw_n) begin
    if (!rst_draw_n) begin
      scroll_x_q <= '0;
      scroll_y_q <= '0;
      addr_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      have_q <= 1'b0;
    end else begin
      scroll_x_q <= scroll_x_d;
      scroll_y_q <= scroll_y_d;
      addr_q <= addr_d;
      v1_q <= rd_valid;
      v2_q <= v1_q;
      have_q <= have_q | v1_q;
    end
  end
  // The RAM output register has no reset (block RAM friendly); have_q masks it to 0 until a post-reset read lands.
  assign rd_data = have_q ? ram_q : '0;
  assign rd_data_valid = v2_q;
  assign wr_ready = rst_draw_n & ~rd_valid;
  tile_map_ram #(.AW(AW), .DATA_W(DATA_W), .FILENAME(FILENAME)) u_ram (
    .clk(clk_draw),
    .wr_be_i((wr_valid && wr_ready) ? wr_be : '0),
    .wr_addr_i({wr_y, wr_x}),
    .wr_data_i(wr_data),
    .rd_en_i(v1_q),
    .rd_addr_i(addr_q),
    .rd_data_o(ram_q)
  );
endmodule
